control_sequencer: RTL and testbench

Hardwired control unit for the 32-bit register-bus datapath. Steps one instruction at a time through a fixed T-state sequence (fetch T0–T2, execute T3–T7). In each state it drives the datapath's register-enable, bus-select, memory and register-file select strobes. It replaces hand-sequenced stimulus and sits directly beside `datapath`, taking `IR` and `CON` back from it.

---
 rtl/control_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for the 32-bit register-bus datapath.
// Steps RESET -> T0..T7 -> T0 per instruction and decodes strobes from state and opcode.
module control_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        Run,
  output logic [4:0]  alu_op,
  output logic        HIin,
  output logic        LOin,
  output logic        PCin,
  output logic        MDRin,
  output logic        Zin,
  output logic        Yin,
  output logic        MARin,
  output logic        IRin,
  output logic        CONin,
  output logic        OUTPORTin,
  output logic        HIout,
  output logic        LOout,
  output logic        ZHIout,
  output logic        ZLOout,
  output logic        PCout,
  output logic        MDRout,
  output logic        INPORTout,
  output logic        Cout,
  output logic        BAout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        Read,
  output logic        write,
  output logic        IncPC
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_UNARY, C_LDI, C_LD, C_ST, C_MULDIV, C_BRANCH,
    C_JAL, C_JR, C_IN, C_OUT, C_MFLO, C_MFHI, C_NOP, C_HALT
  } op_class_e;

  localparam logic [4:0] OP_ADD = 5'b00011;

  state_e      state, state_n, last_state;
  op_class_e   op_class;
  logic [4:0]  opcode;
  logic        unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  always_comb begin
    op_class = C_NOP;
    case (opcode) inside
      [5'b00011:5'b01011]: op_class = C_ALU;
      [5'b01100:5'b01110]: op_class = C_IMM;
      5'b10001, 5'b10010:  op_class = C_UNARY;
      5'b00001:            op_class = C_LDI;
      5'b00000:            op_class = C_LD;
      5'b00010:            op_class = C_ST;
      5'b01111, 5'b10000:  op_class = C_MULDIV;
      5'b10011:            op_class = C_BRANCH;
      5'b10100:            op_class = C_JAL;
      5'b10101:            op_class = C_JR;
      5'b10110:            op_class = C_IN;
      5'b10111:            op_class = C_OUT;
      5'b11000:            op_class = C_MFLO;
      5'b11001:            op_class = C_MFHI;
      5'b11011:            op_class = C_HALT;
      default:             op_class = C_NOP;
    endcase
  end

  // Final execute state of each instruction class; it returns to T0 afterwards.
  always_comb begin
    case (op_class)
      C_ALU, C_IMM, C_LDI: last_state = S_T5;
      C_UNARY, C_JAL:      last_state = S_T4;
      C_LD, C_ST:          last_state = S_T7;
      C_MULDIV, C_BRANCH:  last_state = S_T6;
      default:             last_state = S_T3;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_RESET: state_n = S_T0;
      S_T0:    state_n = S_T1;
      S_T1:    state_n = S_T2;
      S_T2:    state_n = S_T3;
      S_T3:    state_n = (op_class == C_HALT)    ? S_HALT :
                         (last_state == S_T3)    ? S_T0   : S_T4;
      S_T4:    state_n = (last_state == S_T4) ? S_T0 : S_T5;
      S_T5:    state_n = (last_state == S_T5) ? S_T0 : S_T6;
      S_T6:    state_n = (last_state == S_T6) ? S_T0 : S_T7;
      S_T7:    state_n = S_T0;
      S_HALT:  state_n = S_HALT;
      default: state_n = S_RESET;
    endcase
  end

  // NOTE: state uses non-blocking assignment; Reset is sampled only on the clock edge.
  always_ff @(posedge Clock) begin
    if (!Reset) state <= S_RESET;
    else        state <= state_n;
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    Run    = (state != S_RESET) && (state != S_HALT);
    alu_op = opcode;
    {HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin} = '0;
    {HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, BAout} = '0;
    {Gra, Grb, Grc, Rin, Rout} = '0;
    {Read, write, IncPC} = '0;
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; PCin = 1'b1; IncPC = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (op_class)
          C_ALU, C_IMM:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_UNARY:           begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
          C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_MULDIV:          begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_BRANCH:          begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          C_JAL:             begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          C_JR:              begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          C_IN:              begin INPORTout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_OUT:             begin Gra = 1'b1; Rout = 1'b1; OUTPORTin = 1'b1; end
          C_MFLO:            begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_MFHI:            begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op_class)
          C_ALU:             begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
          C_IMM:             begin Cout = 1'b1; Zin = 1'b1; end
          C_UNARY:           begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
          C_MULDIV:          begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
          C_BRANCH:          begin PCout = 1'b1; Yin = 1'b1; end
          C_JAL:             begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op_class)
          C_ALU, C_IMM, C_LDI: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LD, C_ST:          begin ZLOout = 1'b1; MARin = 1'b1; end
          C_MULDIV:            begin ZLOout = 1'b1; LOin = 1'b1; end
          C_BRANCH:            begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
          default: ;
        endcase
      end
      S_T6: begin
        case (op_class)
          C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          C_MULDIV: begin ZHIout = 1'b1; HIin = 1'b1; end
          C_BRANCH: begin ZLOout = CON; PCin = CON; end
          default: ;
        endcase
      end
      S_T7: begin
        case (op_class)
          C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST:    write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the stimulus process queues hand-computed
// per-cycle expectations, a monitor pops and compares them on the falling edge.
module tb_control_sequencer;

  typedef logic [26:0] strobes_t;

  localparam strobes_t HIIN      = 27'h1 << 0;
  localparam strobes_t LOIN      = 27'h1 << 1;
  localparam strobes_t PCIN      = 27'h1 << 2;
  localparam strobes_t MDRIN     = 27'h1 << 3;
  localparam strobes_t ZIN       = 27'h1 << 4;
  localparam strobes_t YIN       = 27'h1 << 5;
  localparam strobes_t MARIN     = 27'h1 << 6;
  localparam strobes_t IRIN      = 27'h1 << 7;
  localparam strobes_t CONIN     = 27'h1 << 8;
  localparam strobes_t OUTPORTIN = 27'h1 << 9;
  localparam strobes_t HIOUT     = 27'h1 << 10;
  localparam strobes_t LOOUT     = 27'h1 << 11;
  localparam strobes_t ZHIOUT    = 27'h1 << 12;
  localparam strobes_t ZLOOUT    = 27'h1 << 13;
  localparam strobes_t PCOUT     = 27'h1 << 14;
  localparam strobes_t MDROUT    = 27'h1 << 15;
  localparam strobes_t INPORTOUT = 27'h1 << 16;
  localparam strobes_t COUT      = 27'h1 << 17;
  localparam strobes_t BAOUT     = 27'h1 << 18;
  localparam strobes_t GRA       = 27'h1 << 19;
  localparam strobes_t GRB       = 27'h1 << 20;
  localparam strobes_t GRC       = 27'h1 << 21;
  localparam strobes_t RIN       = 27'h1 << 22;
  localparam strobes_t ROUT      = 27'h1 << 23;
  localparam strobes_t READ      = 27'h1 << 24;
  localparam strobes_t WRITE     = 27'h1 << 25;
  localparam strobes_t INCPC     = 27'h1 << 26;
  localparam strobes_t NONE      = '0;

  localparam logic [31:0] IR_JUNK = 32'hDEADBEEF;
  localparam logic [31:0] IR_MFLO = 32'hC3000000;
  localparam logic [31:0] IR_ADD  = 32'h18A30000;
  localparam logic [31:0] IR_LD   = 32'h00800010;
  localparam logic [31:0] IR_ST   = 32'h10800020;
  localparam logic [31:0] IR_BR   = 32'h98800004;
  localparam logic [31:0] IR_MUL  = 32'h80000000;
  localparam logic [31:0] IR_JAL  = 32'hA0000000;
  localparam logic [31:0] IR_UND  = 32'hE0000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [4:0]  ADD     = 5'b00011;
  localparam int          WATCHDOG_CYCLES = 2000;

  typedef struct {
    string      name;
    logic       run;
    logic [4:0] alu;
    strobes_t   s;
  } exp_t;

  logic        Clock, Reset, CON;
  logic [31:0] IR;
  logic        Run;
  logic [4:0]  alu_op;
  logic HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
  logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, BAout;
  logic Gra, Grb, Grc, Rin, Rout, Read, write, IncPC;

  exp_t     sb_q[$];
  int       n_cmp = 0;
  int       n_bad = 0;
  logic     done  = 1'b0;
  strobes_t act;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .CON(CON), .Run(Run), .alu_op(alu_op),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .IRin(IRin), .CONin(CONin), .OUTPORTin(OUTPORTin),
    .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
    .MDRout(MDRout), .INPORTout(INPORTout), .Cout(Cout), .BAout(BAout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .Read(Read), .write(write), .IncPC(IncPC)
  );

  assign act = {IncPC, write, Read, Rout, Rin, Grc, Grb, Gra, BAout, Cout, INPORTout,
                MDRout, PCout, ZLOout, ZHIout, LOout, HIout, OUTPORTin, CONin, IRin,
                MARin, Yin, Zin, MDRin, PCin, LOin, HIin};

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string name, input logic ok, input string detail);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // One clock cycle: inputs held for the cycle, plus the outputs expected during it.
  task automatic cyc(input string name, input logic [31:0] ir, input logic con,
                     input logic rst, input logic run, input logic [4:0] alu,
                     input strobes_t s);
    exp_t e;
    @(posedge Clock);
    #1;
    IR    = ir;
    CON   = con;
    Reset = rst;
    e.name = name;
    e.run  = run;
    e.alu  = alu;
    e.s    = s;
    sb_q.push_back(e);
  endtask

  task automatic fetch(input string tag, input logic [31:0] ir, input logic con);
    cyc({tag, " T0"}, ir, con, 1'b1, 1'b1, ir[31:27], PCOUT | MARIN);
    cyc({tag, " T1"}, ir, con, 1'b1, 1'b1, ir[31:27], READ | MDRIN | PCIN | INCPC);
    cyc({tag, " T2"}, ir, con, 1'b1, 1'b1, ir[31:27], MDROUT | IRIN);
  endtask

  task automatic ex(input string name, input logic [31:0] ir, input logic con,
                    input logic [4:0] alu, input strobes_t s);
    cyc(name, ir, con, 1'b1, 1'b1, alu, s);
  endtask

  initial begin
    Reset = 1'b0;
    IR    = IR_JUNK;
    CON   = 1'b0;

    cyc("reset hold 1", IR_JUNK, 1'b0, 1'b0, 1'b0, 5'b11011, NONE);
    cyc("reset hold 2", IR_JUNK, 1'b0, 1'b0, 1'b0, 5'b11011, NONE);
    cyc("reset release", IR_JUNK, 1'b0, 1'b1, 1'b0, 5'b11011, NONE);

    fetch("mflo", IR_MFLO, 1'b0);
    ex("mflo T3", IR_MFLO, 1'b0, 5'b11000, LOOUT | GRA | RIN);

    fetch("add", IR_ADD, 1'b0);
    ex("add T3", IR_ADD, 1'b0, ADD, GRB | ROUT | YIN);
    ex("add T4", IR_ADD, 1'b0, ADD, GRC | ROUT | ZIN);
    ex("add T5", IR_ADD, 1'b0, ADD, ZLOOUT | GRA | RIN);

    fetch("ld", IR_LD, 1'b0);
    ex("ld T3", IR_LD, 1'b0, 5'b00000, GRB | BAOUT | YIN);
    ex("ld T4", IR_LD, 1'b0, ADD, COUT | ZIN);
    ex("ld T5", IR_LD, 1'b0, 5'b00000, ZLOOUT | MARIN);
    ex("ld T6", IR_LD, 1'b0, 5'b00000, READ | MDRIN);
    ex("ld T7", IR_LD, 1'b0, 5'b00000, MDROUT | GRA | RIN);

    fetch("st", IR_ST, 1'b0);
    ex("st T3", IR_ST, 1'b0, 5'b00010, GRB | BAOUT | YIN);
    ex("st T4", IR_ST, 1'b0, ADD, COUT | ZIN);
    ex("st T5", IR_ST, 1'b0, 5'b00010, ZLOOUT | MARIN);
    ex("st T6", IR_ST, 1'b0, 5'b00010, GRA | ROUT | MDRIN);
    ex("st T7", IR_ST, 1'b0, 5'b00010, WRITE);

    fetch("br1", IR_BR, 1'b1);
    ex("br1 T3", IR_BR, 1'b1, 5'b10011, GRA | ROUT | CONIN);
    ex("br1 T4", IR_BR, 1'b1, 5'b10011, PCOUT | YIN);
    ex("br1 T5", IR_BR, 1'b1, ADD, COUT | ZIN);
    ex("br1 T6", IR_BR, 1'b1, 5'b10011, ZLOOUT | PCIN);

    fetch("br0", IR_BR, 1'b0);
    ex("br0 T3", IR_BR, 1'b0, 5'b10011, GRA | ROUT | CONIN);
    ex("br0 T4", IR_BR, 1'b0, 5'b10011, PCOUT | YIN);
    ex("br0 T5", IR_BR, 1'b0, ADD, COUT | ZIN);
    ex("br0 T6", IR_BR, 1'b0, 5'b10011, NONE);

    fetch("mul", IR_MUL, 1'b0);
    ex("mul T3", IR_MUL, 1'b0, 5'b10000, GRA | ROUT | YIN);
    ex("mul T4", IR_MUL, 1'b0, 5'b10000, GRB | ROUT | ZIN);
    ex("mul T5", IR_MUL, 1'b0, 5'b10000, ZLOOUT | LOIN);
    ex("mul T6", IR_MUL, 1'b0, 5'b10000, ZHIOUT | HIIN);

    fetch("jal", IR_JAL, 1'b0);
    ex("jal T3", IR_JAL, 1'b0, 5'b10100, PCOUT | GRB | RIN);
    ex("jal T4", IR_JAL, 1'b0, 5'b10100, GRA | ROUT | PCIN);

    fetch("undef", IR_UND, 1'b0);
    ex("undef T3", IR_UND, 1'b0, 5'b11100, NONE);

    fetch("halt", IR_HALT, 1'b0);
    ex("halt T3", IR_HALT, 1'b0, 5'b11011, NONE);
    for (int i = 0; i < 10; i++)
      cyc("halt hold", IR_HALT, 1'b0, 1'b1, 1'b0, 5'b11011, NONE);
    cyc("halt reset req", IR_HALT, 1'b0, 1'b0, 1'b0, 5'b11011, NONE);
    cyc("reset after halt", IR_LD, 1'b0, 1'b1, 1'b0, 5'b00000, NONE);

    fetch("ld2", IR_LD, 1'b0);
    ex("ld2 T3", IR_LD, 1'b0, 5'b00000, GRB | BAOUT | YIN);
    ex("ld2 T4", IR_LD, 1'b0, ADD, COUT | ZIN);
    ex("ld2 T5", IR_LD, 1'b0, 5'b00000, ZLOOUT | MARIN);
    cyc("ld2 T6 reset", IR_LD, 1'b0, 1'b0, 1'b1, 5'b00000, READ | MDRIN);
    cyc("ld2 aborted", IR_LD, 1'b0, 1'b1, 1'b0, 5'b00000, NONE);
    cyc("T0 after abort", IR_LD, 1'b0, 1'b1, 1'b1, 5'b00000, PCOUT | MARIN);

    done = 1'b1;
  end

  initial begin
    @(negedge Clock);
    check("reset state", (Run === 1'b0) && (act === NONE),
          $sformatf("got Run=%b strobes=%h, expected Run=0 strobes=0", Run, act));
  end

  initial begin
    repeat (WATCHDOG_CYCLES) @(posedge Clock);
    check("watchdog", 1'b0,
          $sformatf("scoreboard not drained after %0d cycles (%0d pending)",
                    WATCHDOG_CYCLES, sb_q.size()));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, (Run === e.run) && (alu_op === e.alu) && (act === e.s),
              $sformatf("got Run=%b alu_op=%b strobes=%h, expected Run=%b alu_op=%b strobes=%h",
                        Run, alu_op, act, e.run, e.alu, e.s));
      end else if (done) begin
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

endmodule
